exe_mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide sequencer beside the single-cycle ALU in the EXE stage. It accepts MULT/MULTU/DIV/DIVU requests, runs a radix-2 iterative datapath over a fixed 32-step schedule, and owns the architectural HI/LO registers. While it is busy it raises a stall so that the pipeline holds EXE. MTHI/MTLO writes and a pipeline flush are also handled here.

---
 rtl/exe_mdu_ctrl.sv | 152 +++++++++++++++
 tb/tb_exe_mdu_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/exe_mdu_ctrl.sv
// exe_mdu_ctrl -- multi-cycle multiply/divide sequencer for the EXE stage.
//
// Runs MULTU/MULT/DIVU/DIV over a fixed 32-step radix-2 schedule and owns
// the architectural HI/LO registers. Start in cycle 0 produces RUN in
// cycles 1-32, FIX in cycle 33, and the done pulse in cycle 34.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start, op     request (00 MULTU, 01 MULT, 10 DIVU, 11 DIV), idle only
//   a, b          operands (multiplicand/dividend, multiplier/divisor)
//   flush         abort in-flight op / discard same-cycle start
//   hi_we, lo_we  MTHI/MTLO enables (idle only), data on wdata
//   busy          op in progress (stall EXE)
//   done          one-cycle pulse with fresh HI/LO
//   hi, lo        HI/LO registers
module exe_mdu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      r_state, w_next;
    logic [1:0]  r_op;
    logic        r_sa, r_sb;
    logic [31:0] r_b;        // multiplicand (mul) or divisor (div), magnitude
    logic [63:0] r_acc;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [4:0]  r_cnt;
    logic        r_done;
    logic [31:0] r_hi, r_lo;

    logic [31:0] w_abs_a, w_abs_b;
    logic [32:0] w_msum, w_shift, w_diff;
    logic        w_ge;
    logic [63:0] w_mul_acc, w_div_acc, w_prod;
    logic [31:0] w_quo, w_rem;
    logic        w_signed;

    assign w_signed = r_op[0];
    assign w_abs_a  = (op[0] && a[31]) ? -a : a;
    assign w_abs_b  = (op[0] && b[31]) ? -b : b;

    // Shift-add: conditionally add multiplicand to the upper half, carry
    // shifts back in as the new MSB.
    assign w_msum    = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_acc = {w_msum, r_acc[31:1]};

    // Restoring divide: remainder stays below the divisor, so 32 stored bits
    // suffice; the shifted trial value needs 33.
    assign w_shift   = {r_acc[63:32], r_acc[31]};
    assign w_ge      = (w_shift >= {1'b0, r_b});
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_div_acc = {(w_ge ? w_diff[31:0] : w_shift[31:0]), r_acc[30:0], w_ge};

    assign w_prod = (w_signed && (r_sa ^ r_sb)) ? -r_acc : r_acc;
    assign w_quo  = (w_signed && (r_sa ^ r_sb)) ? -r_acc[31:0] : r_acc[31:0];
    // Remainder follows the dividend sign; with a zero divisor this restores a.
    assign w_rem  = (w_signed && r_sa) ? -r_acc[63:32] : r_acc[63:32];

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start && !flush) w_next = S_RUN;
            S_RUN: begin
                if (flush)              w_next = S_IDLE;
                else if (r_cnt == 5'd31) w_next = S_FIX;
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= 2'd0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_b    <= 32'd0;
            r_acc  <= 64'd0;
            r_cnt  <= 5'd0;
            r_done <= 1'b0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        // flush beats start and MTHI/MTLO alike
                    end else if (start) begin
                        r_op  <= op;
                        r_sa  <= a[31];
                        r_sb  <= b[31];
                        r_cnt <= 5'd0;
                        if (op[1]) begin
                            r_b   <= w_abs_b;
                            r_acc <= {32'd0, w_abs_a};
                        end else begin
                            r_b   <= w_abs_a;
                            r_acc <= {32'd0, w_abs_b};
                        end
                    end else begin
                        if (hi_we) r_hi <= wdata;
                        if (lo_we) r_lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + 5'd1;
                        r_acc <= r_op[1] ? w_div_acc : w_mul_acc;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_op[1]) begin
                            r_lo <= (r_b == 32'd0) ? 32'hFFFF_FFFF : w_quo;
                            r_hi <= w_rem;
                        end else begin
                            r_lo <= w_prod[31:0];
                            r_hi <= w_prod[63:32];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_exe_mdu_ctrl.sv
// Directed bench for exe_mdu_ctrl. Inputs change 1 time unit after the
// rising edge and outputs are checked there too, so "cycle N" below is the
// interval after the Nth edge counted from the start cycle.
module tb_exe_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, flush, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int nvec = 0;
    int nerr = 0;

    exe_mdu_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive start in the current cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
        op = o; a = va; b = vb; start = 1'b1;
        chk("busy_c0", {31'd0, busy}, 32'd0);
        tick();
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    endtask

    // From cycle 1, run to cycle 34 and check the result.
    task automatic finish(input string tag, input logic [31:0] eh, input logic [31:0] el);
        chk({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
        repeat (32) tick();
        chk({tag, "_busy_c33"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_c33"}, {31'd0, done}, 32'd0);
        tick();
        chk({tag, "_done_c34"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_c34"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    task automatic set_hilo(input logic [31:0] vh, input logic [31:0] vl);
        hi_we = 1'b1; wdata = vh; tick(); hi_we = 1'b0;
        lo_we = 1'b1; wdata = vl; tick(); lo_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'd0; a = 32'd0; b = 32'd0; wdata = 32'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // Back-to-back arithmetic: each issue happens in the previous done cycle.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish("multu", 32'hFFFF_FFFE, 32'h0000_0001);
        issue(2'b01, 32'hFFFF_FFFD, 32'd5);         finish("mult",  32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000); finish("mult_min", 32'h4000_0000, 32'h0000_0000);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);         finish("div",   32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF); finish("div_ovf", 32'h0000_0000, 32'h8000_0000);
        issue(2'b10, 32'h0000_1234, 32'd0);         finish("divu_z", 32'h0000_1234, 32'hFFFF_FFFF);
        issue(2'b11, 32'hFFFF_FFFB, 32'd0);         finish("div_z",  32'hFFFF_FFFB, 32'hFFFF_FFFF);
        tick();
        chk("done_pulse_end", {31'd0, done}, 32'd0);

        // Simultaneous MTHI + MTLO write both registers.
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678; tick();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("both_we_hi", hi, 32'h1234_5678);
        chk("both_we_lo", lo, 32'h1234_5678);

        // Start while busy is ignored; MTHI while busy is ignored.
        set_hilo(32'hAAAA_AAAA, 32'h5555_5555);
        issue(2'b10, 32'd100, 32'd7);            // now cycle 1
        repeat (9) tick();                        // cycle 10
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd1;
        tick();                                   // cycle 11
        start = 1'b0;
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();                                   // cycle 12
        hi_we = 1'b0;
        chk("busy_mthi_hi", hi, 32'hAAAA_AAAA);
        repeat (21) tick();                       // cycle 33
        chk("sb_busy_c33", {31'd0, busy}, 32'd1);
        tick();                                   // cycle 34
        chk("sb_done", {31'd0, done}, 32'd1);
        chk("sb_lo", lo, 32'd14);
        chk("sb_hi", hi, 32'd2);

        // Flush in cycle 20 aborts with no done and HI/LO untouched.
        set_hilo(32'hAAAA_AAAA, 32'h5555_5555);
        issue(2'b10, 32'd100, 32'd7);
        repeat (19) tick();                       // cycle 20
        flush = 1'b1;
        tick();                                   // cycle 21
        flush = 1'b0;
        chk("fl_busy_c21", {31'd0, busy}, 32'd0);
        repeat (13) tick();                       // cycle 34
        chk("fl_done_c34", {31'd0, done}, 32'd0);
        chk("fl_hi", hi, 32'hAAAA_AAAA);
        chk("fl_lo", lo, 32'h5555_5555);

        // Flush in idle discards a same-cycle start.
        flush = 1'b1; start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
        tick();
        flush = 1'b0; start = 1'b0;
        chk("fl_idle_busy", {31'd0, busy}, 32'd0);

        // MTHI in idle.
        hi_we = 1'b1; wdata = 32'hCAFE_BABE; tick(); hi_we = 1'b0;
        chk("mthi", hi, 32'hCAFE_BABE);

        // start + MTLO: start wins.
        lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
        issue(2'b00, 32'd2, 32'd3);
        chk("st_lo_dropped", lo, 32'h5555_5555);
        finish("st_lo", 32'd0, 32'd6);

        // Reset mid-operation (cycle 15).
        issue(2'b00, 32'hFFFF_FFFF, 32'd7);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_hi", hi, 32'd0);
        chk("mrst_lo", lo, 32'd0);
        repeat (20) tick();
        chk("mrst_no_done", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
